// File: rtl/div_seq_ctrl_if.sv
// ============================================================================
// Module   : div_seq_ctrl_if
// Brief    : Issue/result bundle between the E-stage divide issue logic and
//            the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_seq_ctrl_if;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        stall_div;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output start, signed_div, a, b, cancel,
    input  stall_div, result_valid, quotient, remainder
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output stall_div, result_valid, quotient, remainder
  );
endinterface

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
// ============================================================================
// Module   : div_seq_ctrl
// Brief    : 32-bit restoring divider, one quotient bit per cycle, stalling
//            the pipeline front end while busy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq_ctrl (
  input  logic          clk,
  input  logic          resetn,
  div_seq_ctrl_if.slave bus
);

  localparam logic [4:0]  C_LAST_STEP = 5'd31;
  localparam logic [31:0] C_ALL_ONES  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic        r_negQ;
  logic        r_negR;
  logic        r_resultValid;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;

  logic [31:0] w_aMag;
  logic [31:0] w_bMag;
  logic [32:0] w_shifted;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_nextRem;
  logic [31:0] w_nextQuo;

  assign w_aMag = (bus.signed_div && bus.a[31]) ? -bus.a : bus.a;
  assign w_bMag = (bus.signed_div && bus.b[31]) ? -bus.b : bus.b;

  // r_quo starts as the dividend magnitude and fills with quotient bits from the right
  assign w_shifted = {r_rem, r_quo[31]};
  assign w_diff    = w_shifted - {1'b0, r_divisor};
  assign w_fits    = ~w_diff[32];
  assign w_nextRem = w_fits ? w_diff[31:0] : w_shifted[31:0];
  assign w_nextQuo = {r_quo[30:0], w_fits};

  // Reset gating keeps the hazard unit free while the divider is held in reset
  assign bus.stall_div = resetn && !bus.cancel &&
                         (((r_state == IDLE) && bus.start) || (r_state == BUSY));

  assign bus.result_valid = r_resultValid;
  assign bus.quotient     = r_quotient;
  assign bus.remainder    = r_remainder;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_divisor     <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_negQ        <= 1'b0;
      r_negR        <= 1'b0;
      r_resultValid <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
    end else begin
      r_resultValid <= 1'b0;
      if (bus.cancel) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              if (bus.b == '0) begin
                r_quotient    <= C_ALL_ONES;
                r_remainder   <= bus.a;
                r_resultValid <= 1'b1;
                r_state       <= DONE;
              end else begin
                r_divisor <= w_bMag;
                r_quo     <= w_aMag;
                r_rem     <= '0;
                r_count   <= '0;
                r_negQ    <= bus.signed_div && (bus.a[31] ^ bus.b[31]);
                r_negR    <= bus.signed_div && bus.a[31];
                r_state   <= BUSY;
              end
            end
          end
          BUSY: begin
            r_rem   <= w_nextRem;
            r_quo   <= w_nextQuo;
            r_count <= r_count + 5'd1;
            if (r_count == C_LAST_STEP) begin
              r_quotient    <= r_negQ ? -w_nextQuo : w_nextQuo;
              r_remainder   <= r_negR ? -w_nextRem : w_nextRem;
              r_resultValid <= 1'b1;
              r_state       <= DONE;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk input 1 (rising edge), resetn input 1 (asynchronous, active-low).
REQ-002 The block SHALL have port start, input, 1 bit: the instruction in the E stage is a divide (DIV/DIVU) and is valid.
REQ-003 The block SHALL have port signed_div, input, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-004 The block SHALL have ports a and b, input, 32 bits each: a = dividend, b = divisor; sampled with start.
REQ-005 The block SHALL have port cancel, input, 1 bit: flush of the E-stage divide (exception or redirect).
REQ-006 The block SHALL have port stall_div, output, 1 bit: feeds the hazard unit's stall_divE and holds F/D/E.
REQ-007 The block SHALL have port result_valid, output, 1 bit: one-cycle pulse, quotient/remainder ready for HI/LO write.
REQ-008 The block SHALL have ports quotient and remainder, output, 32 bits each: to LO and HI respectively.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-010 In IDLE with start=1, cancel=0, b!=0, the block SHALL latch operands, clear the 5-bit iteration counter, and go to BUSY.
REQ-011 In IDLE with start=1, cancel=0, b==0, the block SHALL go directly to DONE with quotient=32'hFFFFFFFF, remainder=a.
REQ-012 stall_div SHALL be combinational: 1 when (IDLE and start and not cancel) or BUSY; 0 in DONE and otherwise.
REQ-013 In BUSY the block SHALL perform one restoring shift-subtract step per cycle on operand magnitudes.
REQ-014 In BUSY the block SHALL increment the counter each cycle and go to DONE after the step at count 31.
REQ-015 Total latency SHALL be 33 stall cycles (1 IDLE + 32 BUSY), result_valid in cycle 33.
REQ-016 In DONE the block SHALL assert result_valid for exactly one cycle, drive stall_div=0, ignore start, and return to IDLE.
REQ-017 For signed_div=1 the block SHALL divide absolute values (two's-complement abs, modulo 2^32).
REQ-018 For signed_div=1 the block SHALL negate the quotient when the operand signs differ.
REQ-019 For signed_div=1 the remainder SHALL take the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, with no trap.
REQ-021 quotient and remainder SHALL hold their last values until the next DONE; they SHALL not be updated in BUSY.
REQ-022 cancel=1 in any state SHALL force the next state to IDLE; no result_valid SHALL occur for the cancelled divide.
REQ-023 cancel SHALL have priority over start in the same cycle.
REQ-024 stall_div SHALL be 0 in any cycle where cancel=1.
REQ-025 A start in the cycle after DONE (a new divide in E) SHALL begin a new operation normally (back-to-back).

Reset
REQ-026 resetn=0 SHALL asynchronously force state to IDLE and clear the counter, the operand registers, quotient, remainder and result_valid to 0.
REQ-027 stall_div SHALL be 0 while resetn=0, including a reset during BUSY; the operation SHALL be discarded.
REQ-028 After resetn deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-029 The bench SHALL cover unsigned 100/7: stall_div high cycles 0..32, result_valid at cycle 33, quotient=14, remainder=2.
REQ-030 The bench SHALL cover signed -7/2 (0xFFFFFFF9/0x2): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; also unsigned 0xFFFFFFF9/2: quotient=0x7FFFFFFC, remainder=1.
REQ-031 The bench SHALL cover signed 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0, latency 33.
REQ-032 The bench SHALL cover 5/0: stall_div high 1 cycle, result_valid next cycle, quotient=0xFFFFFFFF, remainder=5.
REQ-033 The bench SHALL cover cancel at BUSY count 10: stall_div=0 that cycle, state IDLE next, no result_valid, previous quotient/remainder unchanged.
REQ-034 The bench SHALL cover resetn pulse low during BUSY count 20: stall_div and outputs 0 immediately; then back-to-back 9/3 and 10/4 give (3,0) then (2,2) with one non-stall DONE cycle between them.
